div_unit: RTL and testbench



---
 rtl/div_unit.sv | 203 ++++++++++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`timescale 1ns/1ps
// div_unit -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   div_en    in   EX-stage instruction is a divide (held while in EX)
//   div_op    in   [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled at start)
//   op_a      in   [WIDTH-1:0] dividend (sampled at start)
//   op_b      in   [WIDTH-1:0] divisor  (sampled at start)
//   div_kill  in   abort the current divide (pipeline flush)
//   div_done  out  one-cycle pulse, result valid
//   result    out  [WIDTH-1:0] quotient or remainder, held until next DONE
//   busy      out  FSM is not in IDLE
//
// Configuration macro: DIV_EARLY_OUT_EN -- when defined, divide-by-zero and
// signed overflow skip the iterations and complete in the cycle after start.
// Result values are identical either way; only latency differs.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             div_kill,
    output logic             div_done,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Latched operation context
    logic [1:0]       op_q;
    logic [WIDTH-1:0] rem_q;     // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo_q;     // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic             q_neg_q;
    logic             r_neg_q;
    logic             zero_q;
    logic             ovf_q;

    // ------------------------------------------------------------------
    // Start-time operand conditioning
    // ------------------------------------------------------------------
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             ovf;
    logic             start;

    assign is_signed = ~div_op[0];
    assign a_neg     = is_signed & op_a[WIDTH-1];
    assign b_neg     = is_signed & op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;
    assign b_zero    = (op_b == '0);
    assign ovf       = is_signed && (op_a == MIN_NEG) && (op_b == '1);
    assign start     = (state == IDLE) && div_en && !div_kill;
    assign busy      = (state != IDLE);

    // ------------------------------------------------------------------
    // One restoring iteration. The shifted remainder is WIDTH+1 bits; the
    // borrow out of the trial subtraction doubles as the "rem < divisor" test.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign take    = ~diff[WIDTH];
    assign rem_n   = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_n   = {quo_q[WIDTH-2:0], take};

    // ------------------------------------------------------------------
    // Sign correction and special-case substitution on the final iteration.
    // With a zero divisor every trial subtraction succeeds, so the remainder
    // naturally ends up as |op_a| and its sign correction restores op_a; only
    // the quotient needs overriding.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] final_result;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        q_fix = q_neg_q ? -quo_n : quo_n;
        r_fix = r_neg_q ? -rem_n : rem_n;
        if (zero_q) begin
            q_fix = '1;
        end
        if (ovf_q) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
        final_result = op_q[1] ? r_fix : q_fix;
    end

    // ------------------------------------------------------------------
    // Early-out special-case result, computed straight from the inputs
    // ------------------------------------------------------------------
    logic             early_hit;
    logic [WIDTH-1:0] early_result;

`ifdef DIV_EARLY_OUT_EN
    assign early_hit    = b_zero || ovf;
    assign early_result = div_op[1] ? (b_zero ? op_a : '0)
                                    : (b_zero ? '1   : MIN_NEG);
`else
    assign early_hit    = 1'b0;
    assign early_result = '0;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div_done <= 1'b0;
            result   <= '0;
        end else if (div_kill) begin
            // Kill wins over start and completion; result is left untouched.
            state    <= IDLE;
            div_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_done <= 1'b0;
                    if (div_en) begin
                        if (early_hit) begin
                            state    <= DONE;
                            cnt      <= '0;
                            div_done <= 1'b1;
                            result   <= early_result;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_W'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state    <= DONE;
                        div_done <= 1'b1;
                        result   <= final_result;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    div_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    div_done <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the datapath is deliberately left out of reset; it is always
    // loaded at start before anything reads it, so a reset would only add
    // fan-out on rst.
    always_ff @(posedge clk) begin
        if (start) begin
            op_q    <= div_op;
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            zero_q  <= b_zero;
            ovf_q   <= ovf;
        end else if (state == BUSY) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
// tb_div_unit -- directed self-checking bench for div_unit (WIDTH = 32).
// Cycle 0 is the cycle in which IDLE sees div_en; outputs are sampled on
// the falling edge of each later cycle.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_en;
    logic [1:0]  div_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        div_kill;
    logic        div_done;
    logic [31:0] result;
    logic        busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int NORM_CYC = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_CYC = 1;
`else
    localparam int SPEC_CYC = 33;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_en   (div_en),
        .div_op   (div_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .div_kill (div_kill),
        .div_done (div_done),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one divide, drop div_en and scramble operands in cycle 1, then
    // wait (bounded) for the done pulse and check latency and result.
    task automatic run_div(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_cyc);
        int cyc;
        bit seen;
        @(negedge clk);
        div_op = op;
        op_a   = a;
        op_b   = b;
        div_en = 1'b1;
        @(negedge clk);
        div_en = 1'b0;
        op_a   = ~a;
        op_b   = b + 32'd5;
        div_op = ~op;
        check({tag, " busy_c1"}, 32'(busy), 32'd1);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (div_done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " result"}, result, exp);
        @(negedge clk);
        check({tag, " done_1cyc"}, 32'(div_done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " held"}, result, exp);
    endtask

    // Start DIVU 100/7, abort at cycle 10 with kill or reset, confirm no
    // pulse follows and the result register behaves as expected.
    task automatic abort_div(input string tag, input bit use_rst, input logic [31:0] exp_res);
        int pulses;
        @(negedge clk);
        div_op = OP_DIVU;
        op_a   = 32'd100;
        op_b   = 32'd7;
        div_en = 1'b1;
        @(negedge clk);
        div_en = 1'b0;
        repeat (9) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         div_kill = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        div_kill = 1'b0;
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        pulses = 0;
        repeat (40) begin
            if (div_done === 1'b1) pulses++;
            @(negedge clk);
        end
        check({tag, " no_pulse"}, 32'(pulses), 32'd0);
        check({tag, " result"}, result, exp_res);
    endtask

    initial begin
        int cyc;
        int n_pulse;
        int p_cyc[2];
        logic [31:0] p_res[2];

        rst      = 1'b1;
        div_en   = 1'b0;
        div_kill = 1'b0;
        div_op   = 2'b00;
        op_a     = '0;
        op_b     = '0;
        repeat (3) @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset done", 32'(div_done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Unsigned basics
        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, NORM_CYC);
        run_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2,  NORM_CYC);

        // Signed, truncation toward zero
        run_div("div_m7_2",   OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORM_CYC);
        run_div("rem_m7_2",   OP_REM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORM_CYC);
        run_div("div_7_m2",   OP_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_CYC);
        run_div("rem_7_m2",   OP_REM, 32'd7,         32'hFFFF_FFFE, 32'd1,         NORM_CYC);
        run_div("div_m8_m3",  OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         NORM_CYC);
        run_div("rem_m8_m3",  OP_REM, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, NORM_CYC);

        // Divide by zero
        run_div("div_5_0",    OP_DIV,  32'd5,         32'd0, 32'hFFFF_FFFF, SPEC_CYC);
        run_div("rem_5_0",    OP_REM,  32'd5,         32'd0, 32'd5,         SPEC_CYC);
        run_div("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPEC_CYC);
        run_div("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_CYC);
        run_div("divu_5_0",   OP_DIVU, 32'd5,         32'd0, 32'hFFFF_FFFF, SPEC_CYC);
        run_div("remu_5_0",   OP_REMU, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_CYC);

        // Signed overflow, and the same bit patterns unsigned (not special)
        run_div("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_CYC);
        run_div("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPEC_CYC);
        run_div("divu_big",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         NORM_CYC);
        run_div("remu_big",   OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORM_CYC);

        // Back-to-back: DIVU 9/3 then DIVU 8/2 with div_en held high
        @(negedge clk);
        div_op  = OP_DIVU;
        op_a    = 32'd9;
        op_b    = 32'd3;
        div_en  = 1'b1;
        n_pulse = 0;
        p_cyc[0] = 0;
        p_cyc[1] = 0;
        p_res[0] = '0;
        p_res[1] = '0;
        for (cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                op_a = 32'd77;
                op_b = 32'd1;
            end
            if (cyc == 35) div_en = 1'b0;
            if (div_done === 1'b1) begin
                if (n_pulse < 2) begin
                    p_cyc[n_pulse] = cyc;
                    p_res[n_pulse] = result;
                end
                n_pulse++;
                op_a = 32'd8;
                op_b = 32'd2;
            end
        end
        div_en = 1'b0;
        check("b2b pulses", 32'(n_pulse), 32'd2);
        check("b2b first_cyc", 32'(p_cyc[0]), 32'd33);
        check("b2b first_res", p_res[0], 32'd3);
        check("b2b gap", 32'(p_cyc[1] - p_cyc[0]), 32'd34);
        check("b2b second_res", p_res[1], 32'd4);

        // Kill mid-divide: result keeps the previous value (4)
        abort_div("kill", 1'b0, 32'd4);
        run_div("after_kill", OP_DIVU, 32'd200, 32'd9, 32'd22, NORM_CYC);

        // Reset mid-divide: result returns to 0
        abort_div("rst", 1'b1, 32'd0);
        run_div("after_rst", OP_REMU, 32'd200, 32'd9, 32'd2, NORM_CYC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
